// File: rtl/bcu_issue_arbiter.sv
// Round-robin issue of ready branch requests to a single shared BCU, with a
// credit-protected result FIFO that hands BCU results to the ROB.
module bcu_issue_arbiter #(
    parameter int N_REQ      = 2,
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       flush_input,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [3*N_REQ-1:0]         req_op,
    input  logic [32*N_REQ-1:0]        req_Vj,
    input  logic [32*N_REQ-1:0]        req_Vk,
    input  logic [ROB_WIDTH*N_REQ-1:0] req_dest,
    input  logic [32*N_REQ-1:0]        req_pc_fallthrough,
    input  logic [32*N_REQ-1:0]        req_pc_target,
    output logic [2:0]                 bcu_op,
    output logic [31:0]                bcu_Vj,
    output logic [31:0]                bcu_Vk,
    output logic [ROB_WIDTH-1:0]       bcu_dest,
    output logic [31:0]                bcu_pc_fallthrough,
    output logic [31:0]                bcu_pc_target,
    input  logic [ROB_WIDTH-1:0]       bcu_rob_id,
    input  logic                       bcu_taken,
    input  logic [31:0]                bcu_value,
    output logic                       rob_valid,
    input  logic                       rob_ready,
    output logic [ROB_WIDTH-1:0]       rob_id,
    output logic                       rob_taken,
    output logic [31:0]                rob_value
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_found;
    logic                 grant_valid;
    logic                 credit_ok;
    logic [N_REQ-1:0]     elig;
    logic [CNT_W:0]       occupancy;
    logic [CNT_W-1:0]     count;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 drop_q;
    logic                 push;
    logic                 pop;
    logic [2:0]           sel_op;
    logic [31:0]          sel_vj;
    logic [31:0]          sel_vk;
    logic [ROB_WIDTH-1:0] sel_dest;
    logic [31:0]          sel_fallthrough;
    logic [31:0]          sel_target;
    logic [ROB_WIDTH-1:0] fifo_id    [FIFO_DEPTH];
    logic                 fifo_taken [FIFO_DEPTH];
    logic [31:0]          fifo_value [FIFO_DEPTH];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Scan rr_ptr+1, rr_ptr+2, ...; smaller distances are visited last so they win.
    always_comb begin
        elig        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] && (req_dest[ROB_WIDTH*i +: ROB_WIDTH] != '0);
        end
        for (int k = N_REQ; k >= 1; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if ((((int'(rr_ptr) + k) % N_REQ) == i) && elig[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = PTR_W'(i);
                end
            end
        end
    end

    // Results already committed to arrive (in the BCU input or output stage) reserve FIFO slots.
    always_comb begin
        occupancy   = (CNT_W+1)'(count) + (CNT_W+1)'(bcu_dest != '0) + (CNT_W+1)'(bcu_rob_id != '0);
        credit_ok   = occupancy < (CNT_W+1)'(FIFO_DEPTH);
        grant_valid = grant_found && credit_ok && !flush_input;
        req_ready   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = grant_valid && (grant_idx == PTR_W'(i));
        end
    end

    always_comb begin
        sel_op          = '0;
        sel_vj          = '0;
        sel_vk          = '0;
        sel_dest        = '0;
        sel_fallthrough = '0;
        sel_target      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_op          = req_op[3*i +: 3];
                sel_vj          = req_Vj[32*i +: 32];
                sel_vk          = req_Vk[32*i +: 32];
                sel_dest        = req_dest[ROB_WIDTH*i +: ROB_WIDTH];
                sel_fallthrough = req_pc_fallthrough[32*i +: 32];
                sel_target      = req_pc_target[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bcu_op             <= '0;
            bcu_Vj             <= '0;
            bcu_Vk             <= '0;
            bcu_dest           <= '0;
            bcu_pc_fallthrough <= '0;
            bcu_pc_target      <= '0;
            rr_ptr             <= PTR_W'(N_REQ - 1);
        end else if (grant_valid) begin
            bcu_op             <= sel_op;
            bcu_Vj             <= sel_vj;
            bcu_Vk             <= sel_vk;
            bcu_dest           <= sel_dest;
            bcu_pc_fallthrough <= sel_fallthrough;
            bcu_pc_target      <= sel_target;
            rr_ptr             <= grant_idx;
        end else begin
            bcu_op             <= '0;
            bcu_Vj             <= '0;
            bcu_Vk             <= '0;
            bcu_dest           <= '0;
            bcu_pc_fallthrough <= '0;
            bcu_pc_target      <= '0;
        end
    end

    // drop_q discards the single result the BCU sampled at the flush edge.
    assign push = (bcu_rob_id != '0) && !flush_input && !drop_q;
    assign pop  = rob_valid && rob_ready;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= flush_input;
            if (flush_input) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (!push && pop) count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_id[wr_ptr]    <= bcu_rob_id;
            fifo_taken[wr_ptr] <= bcu_taken;
            fifo_value[wr_ptr] <= bcu_value;
        end
    end

    always @(posedge clk_in) begin
        if (rst_n_in && push && !pop) begin
            assert (count != CNT_W'(FIFO_DEPTH));
        end
    end

    assign rob_valid = (count != '0);
    assign rob_id    = rob_valid ? fifo_id[rd_ptr]    : '0;
    assign rob_taken = rob_valid ? fifo_taken[rd_ptr] : 1'b0;
    assign rob_value = rob_valid ? fifo_value[rd_ptr] : '0;

endmodule

// File: tb/tb_bcu_issue_arbiter.sv
// Directed bench for bcu_issue_arbiter: a registered BCU model closes the loop
// from issue to ROB handoff.
module tb_bcu_issue_arbiter;

    logic        clk_in;
    logic        rst_n_in;
    logic        flush_input;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [63:0] req_Vj;
    logic [63:0] req_Vk;
    logic [7:0]  req_dest;
    logic [63:0] req_pc_fallthrough;
    logic [63:0] req_pc_target;
    logic [2:0]  bcu_op;
    logic [31:0] bcu_Vj;
    logic [31:0] bcu_Vk;
    logic [3:0]  bcu_dest;
    logic [31:0] bcu_pc_fallthrough;
    logic [31:0] bcu_pc_target;
    logic [3:0]  bcu_rob_id;
    logic        bcu_taken;
    logic [31:0] bcu_value;
    logic        rob_valid;
    logic        rob_ready;
    logic [3:0]  rob_id;
    logic        rob_taken;
    logic [31:0] rob_value;

    logic [2:0]  op0, op1;
    logic [31:0] vj0, vj1, vk0, vk1, ft0, ft1, tg0, tg1;
    logic [3:0]  dest0, dest1;
    int          checks;
    int          errors;
    int          issues;

    assign req_op             = {op1, op0};
    assign req_Vj             = {vj1, vj0};
    assign req_Vk             = {vk1, vk0};
    assign req_dest           = {dest1, dest0};
    assign req_pc_fallthrough = {ft1, ft0};
    assign req_pc_target      = {tg1, tg0};

    bcu_issue_arbiter #(.N_REQ(2), .ROB_WIDTH(4), .FIFO_DEPTH(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_input(flush_input),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_Vj(req_Vj), .req_Vk(req_Vk), .req_dest(req_dest),
        .req_pc_fallthrough(req_pc_fallthrough), .req_pc_target(req_pc_target),
        .bcu_op(bcu_op), .bcu_Vj(bcu_Vj), .bcu_Vk(bcu_Vk), .bcu_dest(bcu_dest),
        .bcu_pc_fallthrough(bcu_pc_fallthrough), .bcu_pc_target(bcu_pc_target),
        .bcu_rob_id(bcu_rob_id), .bcu_taken(bcu_taken), .bcu_value(bcu_value),
        .rob_valid(rob_valid), .rob_ready(rob_ready), .rob_id(rob_id),
        .rob_taken(rob_taken), .rob_value(rob_value)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic logic branch_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One-cycle BCU: the result for the op held in bcu_* appears the cycle after.
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bcu_rob_id <= '0;
            bcu_taken  <= 1'b0;
            bcu_value  <= '0;
        end else begin
            bcu_rob_id <= bcu_dest;
            bcu_taken  <= (bcu_dest != '0) && branch_taken(bcu_op, bcu_Vj, bcu_Vk);
            bcu_value  <= (bcu_dest == '0) ? 32'h0 :
                          (branch_taken(bcu_op, bcu_Vj, bcu_Vk) ? bcu_pc_target : bcu_pc_fallthrough);
        end
    end

    task automatic next_cycle();
        @(posedge clk_in);
        #2;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        issues = 0;
        rst_n_in = 1'b0;
        flush_input = 1'b0;
        req_valid = 2'b00;
        rob_ready = 1'b0;
        op0 = 3'b000; vj0 = 32'd7; vk0 = 32'd7; ft0 = 32'h104; tg0 = 32'h100; dest0 = 4'd5;
        op1 = 3'b100; vj1 = 32'd5; vk1 = 32'd3; ft1 = 32'h204; tg1 = 32'h200; dest1 = 4'd6;

        #12;
        check_output("reset_bcu_dest", 32'(bcu_dest), 32'd0);
        check_output("reset_rob_valid", 32'(rob_valid), 32'd0);
        check_output("reset_rob_id", 32'(rob_id), 32'd0);
        check_output("reset_rob_value", rob_value, 32'd0);
        rst_n_in = 1'b1;
        next_cycle();

        $display("[TB] issue/result path");
        req_valid = 2'b01;
        rob_ready = 1'b1;
        #1;
        check_output("t1_ready", 32'(req_ready), 32'b01);
        next_cycle();
        req_valid = 2'b00;
        check_output("t1_bcu_dest", 32'(bcu_dest), 32'd5);
        check_output("t1_bcu_vj", bcu_Vj, 32'd7);
        check_output("t1_bcu_target", bcu_pc_target, 32'h100);
        next_cycle();
        check_output("t1_rob_valid_early", 32'(rob_valid), 32'd0);
        next_cycle();
        check_output("t1_rob_valid", 32'(rob_valid), 32'd1);
        check_output("t1_rob_id", 32'(rob_id), 32'd5);
        check_output("t1_rob_taken", 32'(rob_taken), 32'd1);
        check_output("t1_rob_value", rob_value, 32'h100);
        next_cycle();
        check_output("t1_rob_popped", 32'(rob_valid), 32'd0);

        $display("[TB] round-robin");
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_output("t2_ready", 32'(req_ready), (k % 2 == 0) ? 32'b10 : 32'b01);
            next_cycle();
            check_output("t2_bcu_dest", 32'(bcu_dest), (k % 2 == 0) ? 32'd6 : 32'd5);
        end
        req_valid = 2'b00;
        repeat (8) next_cycle();
        check_output("t2_drained", 32'(rob_valid), 32'd0);

        $display("[TB] backpressure");
        dest0 = 4'd1;
        dest1 = 4'd2;
        rob_ready = 1'b0;
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (req_ready != 2'b00) issues++;
            next_cycle();
        end
        check_output("t3_issue_count", 32'(issues), 32'd4);
        check_output("t3_full_ready", 32'(req_ready), 32'b00);
        rob_ready = 1'b1;
        #1;
        check_output("t3_no_pop_credit", 32'(req_ready), 32'b00);
        check_output("t3_head0_id", 32'(rob_id), 32'd2);
        check_output("t3_head0_taken", 32'(rob_taken), 32'd0);
        check_output("t3_head0_value", rob_value, 32'h204);
        next_cycle();
        check_output("t3_head1_id", 32'(rob_id), 32'd1);
        check_output("t3_head1_value", rob_value, 32'h100);
        check_output("t3_resume_ready", 32'(req_ready), 32'b10);
        next_cycle();
        check_output("t3_head2_id", 32'(rob_id), 32'd2);
        next_cycle();
        check_output("t3_head3_id", 32'(rob_id), 32'd1);
        req_valid = 2'b00;
        repeat (8) next_cycle();
        check_output("t3_drained", 32'(rob_valid), 32'd0);

        $display("[TB] flush");
        dest0 = 4'd9;
        req_valid = 2'b01;
        #1;
        check_output("t4_ready", 32'(req_ready), 32'b01);
        next_cycle();
        check_output("t4_bcu_dest", 32'(bcu_dest), 32'd9);
        flush_input = 1'b1;
        #1;
        check_output("t4_flush_no_grant", 32'(req_ready), 32'b00);
        next_cycle();
        flush_input = 1'b0;
        req_valid = 2'b00;
        check_output("t4_bcu_cleared", 32'(bcu_dest), 32'd0);
        check_output("t4_fifo_empty", 32'(rob_valid), 32'd0);
        next_cycle();
        check_output("t4_dropped", 32'(rob_valid), 32'd0);
        next_cycle();
        check_output("t4_dropped_id", 32'(rob_id), 32'd0);
        dest0 = 4'd4;
        req_valid = 2'b01;
        #1;
        check_output("t4_after_ready", 32'(req_ready), 32'b01);
        next_cycle();
        req_valid = 2'b00;
        check_output("t4_after_bcu_dest", 32'(bcu_dest), 32'd4);
        next_cycle();
        next_cycle();
        check_output("t4_after_rob_id", 32'(rob_id), 32'd4);
        next_cycle();
        check_output("t4_after_popped", 32'(rob_valid), 32'd0);

        $display("[TB] ineligible request");
        dest0 = 4'd0;
        dest1 = 4'd3;
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_output("t5_ready", 32'(req_ready), 32'b10);
            next_cycle();
            check_output("t5_bcu_dest", 32'(bcu_dest), 32'd3);
        end
        req_valid = 2'b00;
        repeat (6) next_cycle();
        check_output("t5_drained", 32'(rob_valid), 32'd0);

        $display("[TB] async reset");
        dest0 = 4'd7;
        rob_ready = 1'b0;
        req_valid = 2'b01;
        repeat (4) next_cycle();
        req_valid = 2'b00;
        check_output("t6_pre_rob_valid", 32'(rob_valid), 32'd1);
        check_output("t6_pre_rob_id", 32'(rob_id), 32'd7);
        check_output("t6_pre_bcu_dest", 32'(bcu_dest), 32'd7);
        rst_n_in = 1'b0;
        #1;
        check_output("t6_rst_rob_valid", 32'(rob_valid), 32'd0);
        check_output("t6_rst_rob_id", 32'(rob_id), 32'd0);
        check_output("t6_rst_bcu_dest", 32'(bcu_dest), 32'd0);
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b1;
        next_cycle();
        check_output("t6_no_stale", 32'(rob_valid), 32'd0);
        dest0 = 4'd5;
        dest1 = 4'd6;
        rob_ready = 1'b1;
        req_valid = 2'b11;
        #1;
        check_output("t6_first_ready", 32'(req_ready), 32'b01);
        next_cycle();
        check_output("t6_first_dest", 32'(bcu_dest), 32'd5);
        check_output("t6_second_ready", 32'(req_ready), 32'b10);
        next_cycle();
        check_output("t6_second_dest", 32'(bcu_dest), 32'd6);
        req_valid = 2'b00;
        repeat (4) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
